// File: rtl/mips_if_pkg.sv
// Shared types and defaults for the IF-stage fetch front end.
// Fetch FSM states, reset/NOP defaults and the PC increment.
package mips_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/if_pc_adder.sv
// PC incrementer shared by adder_out and the next-pc path.
// Wraps modulo 2^DATA_W with no carry out.
module if_pc_adder
    import mips_if_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] y
);

    assign y = a + DATA_W'(PC_INC);

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF-stage front end: owns the PC, fetches over req/ack and
// holds {PC+4, instruction, hit} for the IF/ID register.
module instruction_fetch_unit
    import mips_if_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall_i,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] adder_out,
    output logic [DATA_W-1:0] instruction_out,
    output logic              hit
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_inc;
    logic [DATA_W-1:0] target;

    assign target = branch_target & ~DATA_W'(3);

    if_pc_adder #(
        .DATA_W(DATA_W)
    ) u_adder (
        .a(req_addr),
        .y(req_inc)
    );

    // State register; reset overrides any transaction in flight.
    always_ff @(posedge clk) begin
        if (rstn) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state: a redirect without ack must wait out the stale reply.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_ack && !branch_taken) state_next = HOLD;
                else if (imem_ack)             state_next = REQ;
                else if (branch_taken)         state_next = DROP;
            end
            DROP: if (imem_ack) state_next = REQ;
            HOLD: if (branch_taken || !stall_i) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    // Memory port: request held on a stable address until ack.
    always_comb begin
        imem_req  = !rstn && (state == REQ || state == DROP);
        imem_addr = req_addr;
    end

    // PC, request address and IF/ID-facing output registers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            pc              <= DATA_W'(RESET_PC);
            req_addr        <= DATA_W'(RESET_PC);
            hit             <= 1'b0;
            adder_out       <= '0;
            instruction_out <= DATA_W'(NOP_WORD);
        end else begin
            unique case (state)
                IDLE: req_addr <= pc;
                REQ: begin
                    if (imem_ack && !branch_taken) begin
                        instruction_out <= imem_rdata;
                        adder_out       <= req_inc;
                        pc              <= req_inc;
                        hit             <= 1'b1;
                    end else if (branch_taken) begin
                        pc <= target;
                        if (imem_ack) req_addr <= target;
                    end
                end
                DROP: begin
                    if (branch_taken) pc <= target;
                    if (imem_ack)
                        req_addr <= branch_taken ? target : pc;
                end
                HOLD: begin
                    if (branch_taken) begin
                        hit             <= 1'b0;
                        instruction_out <= DATA_W'(NOP_WORD);
                        pc              <= target;
                        req_addr        <= target;
                    end else if (!stall_i) begin
                        hit             <= 1'b0;
                        instruction_out <= DATA_W'(NOP_WORD);
                        req_addr        <= pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // An ack with nothing outstanding is a memory-side protocol error.
    a_no_stray_ack : assert property (
        @(posedge clk) disable iff (rstn)
        !(imem_ack && (state == IDLE || state == HOLD))
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus
// hand-written stall, reset-abort and PC-wrap sequences.
module tb_instruction_fetch_unit;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_hit;
        logic [31:0] e_adder;
        logic [31:0] e_instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall_i;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] adder_out;
    logic [31:0] instruction_out;
    logic        hit;

    int passed = 0;
    int total  = 0;
    vec_t vq[$];

    localparam logic [31:0] DTAG = 32'hC0DE_0000;

    instruction_fetch_unit dut (
        .clk(clk),
        .rstn(rstn),
        .stall_i(stall_i),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .adder_out(adder_out),
        .instruction_out(instruction_out),
        .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic add(input logic s, input logic b,
                       input logic [31:0] t, input logic a,
                       input logic [31:0] d, input logic er,
                       input logic [31:0] ea, input logic eh,
                       input logic [31:0] ead,
                       input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.ack = a;
        v.rdata = d; v.e_req = er; v.e_addr = ea;
        v.e_hit = eh; v.e_adder = ead; v.e_instr = ei;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s,
                         input logic b, input logic [31:0] t,
                         input logic a, input logic [31:0] d);
        @(negedge clk);
        rstn = r; stall_i = s; branch_taken = b;
        branch_target = t; imem_ack = a; imem_rdata = d;
        #1;
    endtask

    task automatic chk(input string name, input logic er,
                       input logic [31:0] ea, input logic eh,
                       input logic [31:0] ead,
                       input logic [31:0] ei);
        total++;
        if (imem_req === er && imem_addr === ea && hit === eh &&
            adder_out === ead && instruction_out === ei) begin
            passed++;
        end else begin
            $display("FAIL %s: got req=%b addr=%h hit=%b adder=%h instr=%h want req=%b addr=%h hit=%b adder=%h instr=%h",
                     name, imem_req, imem_addr, hit, adder_out,
                     instruction_out, er, ea, eh, ead, ei);
        end
    endtask

    initial begin
        rstn = 1'b1; stall_i = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_ack = 1'b0; imem_rdata = '0;

        // reset, then check reset state (IDLE)
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        // fetch 0,4,8 with 1-cycle memory
        add(0,0,0,0,0,                 0,32'h0,0,32'h0,0);
        add(0,0,0,1,DTAG|32'h0,        1,32'h0,0,32'h0,0);
        add(0,0,0,0,0,                 0,32'h0,1,32'h4,DTAG|32'h0);
        add(0,0,0,1,DTAG|32'h4,        1,32'h4,0,32'h4,0);
        add(0,0,0,0,0,                 0,32'h4,1,32'h8,DTAG|32'h4);
        add(0,0,0,1,DTAG|32'h8,        1,32'h8,0,32'h8,0);
        add(0,0,0,0,0,                 0,32'h8,1,32'hC,DTAG|32'h8);
        add(0,0,0,1,DTAG|32'hC,        1,32'hC,0,32'hC,0);
        // redirect to 0x103 in HOLD, stall also high
        add(1,1,32'h103,0,0,           0,32'hC,1,32'h10,DTAG|32'hC);
        add(0,0,0,0,0,                 1,32'h100,0,32'h10,0);
        add(0,0,0,1,DTAG|32'h100,      1,32'h100,0,32'h10,0);
        add(0,0,0,0,0,                 0,32'h100,1,32'h104,DTAG|32'h100);
        // redirect to 0x200 while 0x104 outstanding
        add(0,1,32'h200,0,0,           1,32'h104,0,32'h104,0);
        add(0,0,0,0,0,                 1,32'h104,0,32'h104,0);
        add(0,0,0,1,32'hDEAD_BEEF,     1,32'h104,0,32'h104,0);
        // redirect coincident with ack
        add(0,1,32'h280,1,DTAG|32'h200,1,32'h200,0,32'h104,0);
        // two redirects in DROP, last one wins
        add(1,1,32'h300,0,0,           1,32'h280,0,32'h104,0);
        add(0,1,32'h400,0,0,           1,32'h280,0,32'h104,0);
        add(0,0,0,1,32'hBAD0_BAD0,     1,32'h280,0,32'h104,0);
        add(0,0,0,1,DTAG|32'h400,      1,32'h400,0,32'h104,0);
        add(0,0,0,0,0,                 0,32'h400,1,32'h404,DTAG|32'h400);

        foreach (vq[i]) begin
            drive(0, vq[i].stall, vq[i].br, vq[i].tgt,
                  vq[i].ack, vq[i].rdata);
            chk($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr,
                vq[i].e_hit, vq[i].e_adder, vq[i].e_instr);
        end

        // latency-3 memory then 4-cycle stall in HOLD
        drive(0, 1, 0, 0, 0, 0);
        chk("lat3_w1", 1, 32'h404, 0, 32'h404, 0);
        drive(0, 1, 0, 0, 0, 0);
        chk("lat3_w2", 1, 32'h404, 0, 32'h404, 0);
        drive(0, 1, 0, 0, 1, DTAG|32'h404);
        chk("lat3_ack", 1, 32'h404, 0, 32'h404, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 0, 0, 0);
            chk($sformatf("stall%0d", k), 0, 32'h404, 1,
                32'h408, DTAG|32'h404);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("stall_rel", 0, 32'h404, 1, 32'h408, DTAG|32'h404);
        drive(0, 0, 1, 32'h10, 0, 0);
        chk("req_408", 1, 32'h408, 0, 32'h408, 0);
        drive(0, 0, 0, 0, 1, 32'h1234_5678);
        chk("drop_408", 1, 32'h408, 0, 32'h408, 0);

        // reset pulse with request at 0x10 outstanding
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_in", 0, 32'h10, 0, 32'h408, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_out", 0, 32'h0, 0, 32'h0, 0);
        drive(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        chk("req_0", 1, 32'h0, 0, 32'h0, 0);

        // wrap fetch at 0xFFFF_FFFC
        drive(0, 0, 0, 0, 1, 32'h5555_0000);
        chk("drop_0", 1, 32'h0, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 1, DTAG|32'hFC);
        chk("req_wrap", 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("hold_wrap", 0, 32'hFFFF_FFFC, 1, 32'h0, DTAG|32'hFC);
        drive(0, 0, 0, 0, 0, 0);
        chk("req_after", 1, 32'h0, 0, 32'h0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
